// File: rtl/data_bus_sram_ctrl.sv
// data_bus_sram_ctrl: bridges the CPU data bus to an asynchronous 32-bit SRAM.
// Reads and writes run through a small FSM with programmable wait states.
// The CPU is held off through bus_stall until each access completes.
// Optional feature macro: DATA_BUS_WRITE_BUFFER_EN adds a one-entry posted
// write buffer, so a write issued from IDLE completes with zero wait.
module data_bus_sram_ctrl #(
  parameter int ADDR_W    = 20,
  parameter int READ_WAIT = 1,
  parameter int WE_PULSE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_address,
  input  logic              bus_read,
  input  logic              bus_write,
  input  logic [3:0]        bus_mask,
  input  logic [31:0]       bus_wrdata,
  output logic [31:0]       bus_rddata,
  output logic              bus_stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_o,
  input  logic [31:0]       sram_dq_i,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  localparam int MAX_WAIT = (READ_WAIT > WE_PULSE) ? READ_WAIT : WE_PULSE;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_PULSE - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               done_s;
  logic               rd_last_s;
  logic               pulse_last_s;
  logic [3:0]         mask_src_s;

  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        wdata_r;
  logic [3:0]         mask_r;
  logic [31:0]        rddata_r;

  logic               ce_n_r;
  logic               oe_n_r;
  logic               we_n_r;
  logic               dq_oe_r;
  logic [3:0]         be_n_r;
  logic               ce_n_s;
  logic               oe_n_s;
  logic               we_n_s;
  logic               dq_oe_s;
  logic [3:0]         be_n_s;

  // Byte-lane and out-of-range address bits are deliberately ignored.
  logic               unused_addr_s;
  assign unused_addr_s = ^{bus_address[31:ADDR_W+2], bus_address[1:0]};

  assign rd_last_s    = (state_r == ST_RD)       && (cnt_r == RD_LAST);
  assign pulse_last_s = (state_r == ST_WR_PULSE) && (cnt_r == WE_LAST);

  // The mask is latched on the accept edge, so the entry cycle uses the bus copy.
  assign mask_src_s = (state_r == ST_IDLE) ? bus_mask : mask_r;

  // Access completion: DONE always acks; a buffered write also acks straight from IDLE.
  always_comb begin
    done_s = 1'b0;
`ifdef DATA_BUS_WRITE_BUFFER_EN
    if ((state_r == ST_DONE) || ((state_r == ST_IDLE) && bus_write)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
`else
    if (state_r == ST_DONE) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
`endif
  end

  assign bus_stall = (bus_read | bus_write) & ~done_s;

  // State and wait-counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; a write wins over a simultaneous read.
  always_comb begin
    state_s = state_r;
    cnt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        if (bus_write) begin
          state_s = ST_WR_SETUP;
        end else if (bus_read) begin
          state_s = ST_RD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (rd_last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RD;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        state_s = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (pulse_last_s) begin
          state_s = ST_WR_HOLD;
        end else begin
          state_s = ST_WR_PULSE;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
`ifdef DATA_BUS_WRITE_BUFFER_EN
        state_s = ST_IDLE;
`else
        state_s = ST_DONE;
`endif
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // SRAM strobe values for the state being entered, so they register in step with it.
  always_comb begin
    ce_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    dq_oe_s = 1'b0;
    be_n_s  = 4'hF;
    case (state_s)
      ST_RD: begin
        ce_n_s = 1'b0;
        oe_n_s = 1'b0;
        be_n_s = 4'h0;
      end
      ST_WR_SETUP: begin
        ce_n_s  = 1'b0;
        dq_oe_s = 1'b1;
        be_n_s  = ~mask_src_s;
      end
      ST_WR_PULSE: begin
        ce_n_s  = 1'b0;
        we_n_s  = 1'b0;
        dq_oe_s = 1'b1;
        be_n_s  = ~mask_src_s;
      end
      ST_WR_HOLD: begin
        ce_n_s  = 1'b0;
        dq_oe_s = 1'b1;
        be_n_s  = ~mask_src_s;
      end
      ST_IDLE, ST_DONE: begin
        ce_n_s = 1'b1;
      end
      default: begin
        ce_n_s = 1'b1;
      end
    endcase
  end

  // Registered SRAM strobes; reset drops every strobe at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ce_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      dq_oe_r <= 1'b0;
      be_n_r  <= 4'hF;
    end else begin
      ce_n_r  <= ce_n_s;
      oe_n_r  <= oe_n_s;
      we_n_r  <= we_n_s;
      dq_oe_r <= dq_oe_s;
      be_n_r  <= be_n_s;
    end
  end

  // Request latch on acceptance and read-data capture on the last read wait cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
      mask_r   <= 4'h0;
      rddata_r <= 32'h0000_0000;
    end else begin
      if ((state_r == ST_IDLE) && bus_write) begin
        addr_r  <= bus_address[ADDR_W+1:2];
        wdata_r <= bus_wrdata;
        mask_r  <= bus_mask;
      end else if ((state_r == ST_IDLE) && bus_read) begin
        addr_r <= bus_address[ADDR_W+1:2];
      end else begin
        addr_r <= addr_r;
      end
      if (rd_last_s) begin
        rddata_r <= sram_dq_i;
      end else begin
        rddata_r <= rddata_r;
      end
    end
  end

  assign sram_addr  = addr_r;
  assign sram_dq_o  = wdata_r;
  assign sram_dq_oe = dq_oe_r;
  assign sram_ce_n  = ce_n_r;
  assign sram_oe_n  = oe_n_r;
  assign sram_we_n  = we_n_r;
  assign sram_be_n  = be_n_r;
  assign bus_rddata = rddata_r;

endmodule

// File: tb/tb_data_bus_sram_ctrl.sv
// Bench for data_bus_sram_ctrl: asynchronous SRAM device model plus a
// word-level reference memory updated at bus-acceptance time.
module tb_data_bus_sram_ctrl;

  localparam int ADDR_W = 10;
  localparam int RW     = 1;
  localparam int WP     = 2;
`ifdef DATA_BUS_WRITE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [31:0]       bus_address;
  logic              bus_read;
  logic              bus_write;
  logic [3:0]        bus_mask;
  logic [31:0]       bus_wrdata;
  logic [31:0]       bus_rddata;
  logic              bus_stall;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_dq_o;
  logic [31:0]       sram_dq_i;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [3:0]        sram_be_n;

  data_bus_sram_ctrl #(.ADDR_W(ADDR_W), .READ_WAIT(RW), .WE_PULSE(WP)) dut (
    .clk(clk), .rst(rst),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_mask(bus_mask), .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata),
    .bus_stall(bus_stall), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
    .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM device model: data out while selected and output-enabled, write on we_n rise.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 32'hA5A5_5A5A;

  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0 && sram_dq_oe === 1'b1) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b]) mem[sram_addr][b*8 +: 8] = sram_dq_o[b*8 +: 8];
      end
    end
  end

  // Reference model of what the CPU should see.
  logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
  int n_vec = 0;
  int n_err = 0;
  int drain = 0;                 // cycles of posted-write drain still ahead
  logic [ADDR_W-1:0] last_addr_seen;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus_read  = 1'b0;
      bus_write = 1'b0;
    end
    drain = (n >= drain) ? 0 : drain - n;
  endtask

  // One bus access held until stall drops; measures stall length and strobe activity.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] mask, input string tag);
    int stall_n, we_low, oe_low, exp_stall;
    bit done_f;
    logic first_ce;
    logic [3:0] be_pulse;
    logic [31:0] rdv;
    logic [ADDR_W-1:0] w;
    w = addr[ADDR_W+1:2];
    stall_n = 0; we_low = 0; oe_low = 0; done_f = 1'b0;
    be_pulse = 4'hx; rdv = 32'hx;
    if (wr) exp_stall = drain + (BUF ? 0 : WP + 3);
    else    exp_stall = drain + RW + 1;
    @(negedge clk);
    bus_read = rd; bus_write = wr; bus_address = addr;
    bus_wrdata = data; bus_mask = mask;
    #1;
    first_ce = sram_ce_n;
    for (int c = 0; c < 40 && !done_f; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      if (!sram_we_n) begin we_low++; be_pulse = sram_be_n; end
      if (!sram_oe_n) begin oe_low++; last_addr_seen = sram_addr; end
      if (bus_stall) stall_n++;
      else begin done_f = 1'b1; rdv = bus_rddata; end
    end
    chk({tag, "_no_timeout"}, 32'(done_f), 32'd1);
    chk({tag, "_stall_cycles"}, stall_n, exp_stall);
    chk({tag, "_first_cycle_idle"}, 32'(first_ce), (drain > 0) ? 32'd0 : 32'd1);
    if (rd && !wr) begin
      chk({tag, "_rddata"}, rdv, ref_mem[w]);
      chk({tag, "_oe_cycles"}, oe_low, RW);
    end
    if (wr) begin
      chk({tag, "_no_read_strobe"}, oe_low, 0);
      if (!BUF) begin
        chk({tag, "_we_cycles"}, we_low, WP);
        chk({tag, "_be_n"}, {28'd0, be_pulse}, {28'd0, ~mask});
      end
      ref_mem[w] = merge(ref_mem[w], data, mask);
    end
    drain = (BUF && wr) ? WP + 2 : 0;
  endtask

  initial begin
    logic [31:0] old_w;
    logic [31:0] d;
    logic [3:0] m;
    int wd;
    int cnt;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[10'h100] = 32'hDEAD_BEEF; ref_mem[10'h100] = 32'hDEAD_BEEF;
    rst = 1'b0; bus_read = 1'b0; bus_write = 1'b0;
    bus_address = 32'h0; bus_mask = 4'h0; bus_wrdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_o", sram_dq_o, 32'd0);
    chk("rst_rddata", bus_rddata, 32'd0);
    chk("rst_stall", 32'(bus_stall), 32'd0);
    rst = 1'b1;
    idle(2);

    // Basic read of a preloaded word.
    access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, "read_deadbeef");
    chk("read_sram_addr", 32'(last_addr_seen), 32'h100);
    idle(1);

    // Half-word write: upper half must survive.
    old_w = mem[10'h101];
    access(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 4'b0011, "write_half");
    idle(6);
    chk("write_half_mem", mem[10'h101], {old_w[31:16], 16'h5678});

    // Empty mask still runs the sequence but changes nothing.
    old_w = mem[10'h103];
    access(1'b0, 1'b1, 32'h0000_040C, $urandom, 4'h0, "write_mask0");
    idle(6);
    chk("write_mask0_mem", mem[10'h103], old_w);

    // Read and write together: only the write happens.
    access(1'b1, 1'b1, 32'h0000_0408, 32'hCAFE_F00D, 4'hF, "both_high");
    idle(6);
    chk("both_high_mem", mem[10'h102], 32'hCAFE_F00D);

    // Write followed immediately by a read of the same word.
    access(1'b0, 1'b1, 32'h0000_0410, 32'h0BAD_F00D, 4'hF, "raw_write");
    access(1'b1, 1'b0, 32'h0000_0410, 32'h0, 4'h0, "raw_read");
    idle(8);

    // Reset in the middle of the write pulse.
    @(negedge clk);
    bus_write = 1'b1; bus_read = 1'b0; bus_address = 32'h0000_0800;
    bus_wrdata = 32'h5555_AAAA; bus_mask = 4'hF;
    #1;
    cnt = 0;
    while (sram_we_n !== 1'b0 && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    chk("rst_mid_reached_pulse", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_mid_dq_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_mid_ce_n", 32'(sram_ce_n), 32'd1);
    rst = 1'b1; bus_write = 1'b0;
    drain = 0;
    idle(1);
    access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 4'h0, "read_after_rst");

    // Alternating random write/read stream, back to back.
    wd = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i % 2) == 0) begin
        wd = $urandom_range(0, 15);
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        access(1'b0, 1'b1, {20'd0, 10'(wd), 2'($urandom_range(0, 3))}, d, m, "stream_wr");
      end else begin
        if ((i % 4) == 3) wd = $urandom_range(0, 15);
        access(1'b1, 1'b0, {20'd0, 10'(wd), 2'($urandom_range(0, 3))}, 32'h0, 4'h0,
               "stream_rd");
      end
    end
    idle(8);
    for (int i = 0; i < 16; i++) chk("stream_mem_final", mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_bus_sram_ctrl.md
# data_bus_sram_ctrl

Bridges the CPU data bus to an asynchronous 32-bit external SRAM with programmable wait states, and replaces the zero-latency fake data bus once the CPU moves onto real memory. Sits directly downstream of the CPU data-bus master port. It stalls the pipeline through `bus_stall` until each access completes. The existing unit-test programs (mem, mem_unaligned, llsc) must pass unchanged through it.

## Interface
Parameters:
- `ADDR_W`, 20: SRAM word-address width; `sram_addr = bus_address[ADDR_W+1:2]`.
- `READ_WAIT`, 1: cycles the SRAM is held in read before data capture (≥1).
- `WE_PULSE`, 1: cycles `sram_we_n` is held low (≥1).

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-low reset.
- `bus_address`  in  32: byte address; bits [1:0] are ignored.
- `bus_read`  in  1: read request, held until `bus_stall` is low.
- `bus_write`  in  1: write request, held until `bus_stall` is low.
- `bus_mask`  in  4: byte enables for the write, bit i = byte i.
- `bus_wrdata`  in  32: write data.
- `bus_rddata`  out  32: read data; valid in the cycle `bus_stall` falls for a read.
- `bus_stall`  out  1: combinational; `(bus_read|bus_write) && !done`.
- `sram_addr`  out  ADDR_W: word address.
- `sram_dq_o`  out  32: data driven to the SRAM.
- `sram_dq_i`  in  32: data from the SRAM.
- `sram_dq_oe`  out  1: tristate enable for `sram_dq_o`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each: active-low strobes.
- `sram_be_n`  out  4: active-low byte enables.

## Operation
- All SRAM-side outputs are registered.
- Reset values:
  - `sram_ce_n`, `sram_oe_n`, `sram_we_n` = 1.
  - `sram_be_n` = 4'hF.
  - `sram_dq_oe` = 0.
  - `sram_addr` = 0, `sram_dq_o` = 0, `bus_rddata` = 0.
  - State IDLE.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - `bus_write` → latch address, data and mask; go to WR_SETUP.
  - Else `bus_read` → latch address; go to RD.
  - If both are asserted, the write wins (the read is not performed).
- RD:
  - Drive `ce_n=0`, `oe_n=0`, `be_n=0`.
  - Count READ_WAIT cycles; on the last one capture `sram_dq_i` into `bus_rddata`, then go to DONE.
- WR_SETUP: one cycle with `ce_n=0`, `dq_oe=1`, `be_n=~mask`, `we_n=1`.
- WR_PULSE: `we_n=0` for WE_PULSE cycles.
- WR_HOLD: one cycle with `we_n=1` and data still driven (hold time). Then DONE, or IDLE when the buffer is active (see Configuration).
- DONE:
  - All strobes inactive, `dq_oe=0`.
  - `done`=1, so `bus_stall`=0 and the CPU advances.
  - Next state is IDLE unconditionally. A new request is therefore sampled one cycle later, which keeps each access atomic.
- `bus_rddata` holds its value until the next read capture.
- A mask of 4'h0 on a write still runs the full write sequence with `be_n`=4'hF.

## Timing
- Read: request seen in IDLE at cycle 0 (stall=1).
  - Cycles 1..READ_WAIT in RD.
  - Cycle READ_WAIT+1 is DONE with stall=0 and data valid.
  - Stall is high for READ_WAIT+1 cycles.
- Write, unbuffered: stall is high for WE_PULSE+3 cycles (IDLE, SETUP, PULSE×N, HOLD); DONE follows.
- Back-to-back accesses: minimum one IDLE cycle between DONE and the next access's first strobe cycle.
- Reset mid-access (`rst`=0 at any edge):
  - All strobes go inactive at that edge.
  - The FSM returns to IDLE.
  - No partial write completes beyond the current `we_n` edge.

## Configuration
- `DATA_BUS_WRITE_BUFFER_EN` defined: adds a one-entry posted write buffer.
  - In IDLE with the buffer empty, a write sets `done` in the same cycle, so stall=0 with zero wait. Data, address and mask are captured and drained through SETUP/PULSE/HOLD, then IDLE, skipping DONE.
  - Any request arriving while the buffer drains stalls until the drain returns to IDLE, then proceeds normally.
  - This guarantees read-after-write ordering.
- Undefined: no buffer; every write stalls as described in Timing.

## Test plan
- READ_WAIT=1, SRAM model word 0x100 = 0xDEADBEEF, read 0x00000400 → stall high 2 cycles; `bus_rddata`=0xDEADBEEF in the cycle stall falls; `sram_addr`=0x100.
- Write 0x00000404, data 0x12345678, mask 4'b0011, WE_PULSE=2 → `be_n`=4'b1100, `we_n` low exactly 2 cycles, stall high 5 cycles; model word 0x101 low half becomes 0x5678, upper half unchanged.
- `bus_read` and `bus_write` both high → only the write occurs; `oe_n` never asserts.
- `rst`=0 during WR_PULSE → next edge `we_n`=1, `dq_oe`=0, IDLE; subsequent read returns correct data.
- With `DATA_BUS_WRITE_BUFFER_EN`: write then immediate read of the same address → write stall=0 in the first cycle; read stalls through drain and returns the new value.
- Write/read stream of 16 alternating accesses → all values match the reference memory model; every DONE is followed by exactly one IDLE cycle.
